// File: rtl/ai_i2s_tx_block.sv
// I2S transmitter: a TX FIFO feeds a shift register that is serialized MSB first,
// one bit per clk_en strobe, with the standard one-bit delay after word select changes.
module ai_i2s_tx_block #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          tx_en,
    input  logic                          clk_en,
    input  logic [5:0]                    resolution,
    input  logic                          tswap,
    input  logic                          wr_en,
    input  logic [DATA_WIDTH-1:0]         wr_data,
    input  logic                          underrun_clr,
    output logic                          sd,
    output logic                          ws,
    output logic                          fifo_full,
    output logic                          fifo_empty,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          underrun
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam logic [5:0] MAX_BITS = (DATA_WIDTH < 32) ? 6'(DATA_WIDTH) : 6'd32;

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_SHIFT = 1'b1;

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]         level_q, level_d;
    logic                  full_q, full_d;
    logic                  empty_q, empty_d;

    logic [0:0]            state_q, state_d;
    logic [31:0]           shift_q, shift_d;
    logic [4:0]            idx_q, idx_d;
    logic                  sd_q, sd_d;
    logic                  ws_q, ws_d;
    logic                  underrun_q, underrun_d;

    logic [5:0]            actual_bits;
    logic [4:0]            load_idx;
    logic [DATA_WIDTH-1:0] rd_word;
    logic [31:0]           load_word;
    logic                  pop_req;
    logic                  pop_ok;
    logic                  push_ok;

    assign actual_bits = (resolution >= 6'd16 && resolution <= MAX_BITS) ? resolution : 6'd16;
    assign load_idx    = 5'(actual_bits - 6'd1);
    assign rd_word     = mem_q[rd_ptr_q];

    // Half-swap only makes sense for 32-bit containers; narrower words are zero-extended.
    generate
        if (DATA_WIDTH == 32) begin : g_w32
            assign load_word = tswap ? {rd_word[15:0], rd_word[31:16]} : rd_word;
        end else begin : g_w16
            assign load_word = {16'h0000, rd_word};
        end
    endgenerate

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        idx_d      = idx_q;
        sd_d       = sd_q;
        ws_d       = ws_q;
        underrun_d = underrun_q;
        pop_req    = 1'b0;

        if (!tx_en) begin
            state_d = S_IDLE;
            sd_d    = 1'b0;
            ws_d    = 1'b0;
            idx_d   = 5'd0;
        end else if (clk_en) begin
            case (state_q)
                S_IDLE: begin
                    sd_d    = 1'b0;
                    ws_d    = 1'b0;
                    pop_req = 1'b1;
                    state_d = S_SHIFT;
                end
                S_SHIFT: begin
                    sd_d = shift_q[idx_q];
                    if (idx_q != 5'd0) begin
                        idx_d = idx_q - 5'd1;
                    end else begin
                        ws_d    = ~ws_q;
                        pop_req = 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        // A slot starting on an empty FIFO transmits silence and flags it.
        if (pop_req) begin
            shift_d = empty_q ? 32'h0 : load_word;
            idx_d   = load_idx;
        end

        if (pop_req && empty_q) begin
            underrun_d = 1'b1;
        end else if (underrun_clr) begin
            underrun_d = 1'b0;
        end
    end

    always_comb begin
        pop_ok   = pop_req & ~empty_q;
        push_ok  = wr_en & (~full_q | pop_ok);
        wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop_ok ? rd_ptr_q + AW'(1) : rd_ptr_q;
        level_d  = level_q + LW'(push_ok) - LW'(pop_ok);
        full_d   = (level_d == LW'(FIFO_DEPTH));
        empty_d  = (level_d == LW'(0));
    end

    always_ff @(posedge clk) begin
        if (push_ok && !rst) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            state_q    <= S_IDLE;
            shift_q    <= '0;
            idx_q      <= '0;
            sd_q       <= 1'b0;
            ws_q       <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            state_q    <= state_d;
            shift_q    <= shift_d;
            idx_q      <= idx_d;
            sd_q       <= sd_d;
            ws_q       <= ws_d;
            underrun_q <= underrun_d;
        end
    end

    assign sd         = sd_q;
    assign ws         = ws_q;
    assign fifo_full  = full_q;
    assign fifo_empty = empty_q;
    assign fifo_level = level_q;
    assign underrun   = underrun_q;

endmodule

// File: tb/tb_ai_i2s_tx_block.sv
// Bench for ai_i2s_tx_block: a queue-based reference model predicts every cycle's
// outputs; a monitor compares them against the DUT one step after each rising edge.
module tb_ai_i2s_tx_block;

    localparam int DW    = 32;
    localparam int DEPTH = 16;
    localparam int LW    = 5;

    logic          clk = 1'b0;
    logic          rst, tx_en, clk_en, tswap, wr_en, underrun_clr;
    logic [5:0]    resolution;
    logic [DW-1:0] wr_data;
    logic          sd, ws, fifo_full, fifo_empty, underrun;
    logic [LW-1:0] fifo_level;

    always #5 clk = ~clk;

    ai_i2s_tx_block #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .tx_en(tx_en), .clk_en(clk_en),
        .resolution(resolution), .tswap(tswap), .wr_en(wr_en), .wr_data(wr_data),
        .underrun_clr(underrun_clr), .sd(sd), .ws(ws), .fifo_full(fifo_full),
        .fifo_empty(fifo_empty), .fifo_level(fifo_level), .underrun(underrun)
    );

    logic [9:0]  exp_q[$];
    int          n_vec = 0;
    int          n_err = 0;

    // Reference model: FIFO as a queue of words, current slot as a queue of pending bits.
    logic [31:0] m_fifo[$];
    bit          m_bits[$];
    bit          m_sd, m_ws, m_urun, m_inframe, m_urun_set;

    function automatic logic [5:0] ref_bits(input logic [5:0] r);
        if (r >= 16 && r <= 32) return r;
        return 6'd16;
    endfunction

    task automatic load_slot();
        logic [31:0] w;
        int n;
        if (m_fifo.size() > 0) begin
            w = m_fifo.pop_front();
        end else begin
            w = 32'h0;
            m_urun_set = 1'b1;
        end
        if (tswap) w = {w[15:0], w[31:16]};
        n = int'(ref_bits(resolution));
        for (int b = n - 1; b >= 0; b--) m_bits.push_back(w[b]);
    endtask

    task automatic model_step();
        if (rst) begin
            m_fifo.delete();
            m_bits.delete();
            m_sd = 0; m_ws = 0; m_urun = 0; m_inframe = 0;
        end else begin
            m_urun_set = 1'b0;
            if (!tx_en) begin
                m_inframe = 0;
                m_bits.delete();
                m_sd = 0;
                m_ws = 0;
            end else if (clk_en) begin
                if (!m_inframe) begin
                    m_sd = 0;
                    m_ws = 0;
                    m_inframe = 1;
                    load_slot();
                end else begin
                    m_sd = m_bits.pop_front();
                    if (m_bits.size() == 0) begin
                        m_ws = ~m_ws;
                        load_slot();
                    end
                end
            end
            if (wr_en && m_fifo.size() < DEPTH) m_fifo.push_back(wr_data);
            if (m_urun_set) m_urun = 1'b1;
            else if (underrun_clr) m_urun = 1'b0;
        end
    endtask

    task automatic step();
        logic [9:0] e;
        model_step();
        e = {m_sd, m_ws, (m_fifo.size() == DEPTH), (m_fifo.size() == 0), m_urun,
             LW'(m_fifo.size())};
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic push_word(input logic [31:0] w);
        wr_en = 1'b1;
        wr_data = w;
        step();
        wr_en = 1'b0;
    endtask

    task automatic run(input int n, input int period);
        for (int i = 0; i < n; i++) begin
            clk_en = ((i % period) == period - 1);
            step();
        end
        clk_en = 1'b0;
    endtask

    initial begin : monitor
        logic [9:0] e, a;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {sd, ws, fifo_full, fifo_empty, underrun, fifo_level};
                n_vec++;
                if (a !== e) begin
                    n_err++;
                    $display("FAIL outputs{sd,ws,full,empty,urun,level} got %b required %b at %0t",
                             a, e, $time);
                end
            end
        end
    end

    initial begin : driver
        rst = 1'b1; tx_en = 1'b0; clk_en = 1'b0; resolution = 6'd16; tswap = 1'b0;
        wr_en = 1'b0; wr_data = '0; underrun_clr = 1'b0;
        @(negedge clk);
        repeat (3) step();
        rst = 1'b0;
        repeat (2) step();

        // Two known words at 16-bit resolution, bit strobe every 4th cycle.
        push_word(32'h0000A5A5);
        push_word(32'h00003C3C);
        tx_en = 1'b1;
        run(4 * 40, 4);
        tx_en = 1'b0;
        step();

        // Overfill with transmitter off, then drain with a push racing each pop.
        underrun_clr = 1'b1; step(); underrun_clr = 1'b0;
        for (int i = 0; i < 17; i++) push_word($urandom());
        step();
        tx_en = 1'b1;
        for (int i = 0; i < 300; i++) begin
            clk_en = 1'b1;
            wr_en = (i < 40) && ($urandom_range(0, 3) == 0);
            wr_data = $urandom();
            step();
        end
        wr_en = 1'b0;
        tx_en = 1'b0;
        step();

        // Half-swapped 32-bit word, then empty-FIFO underrun with clear pulses.
        underrun_clr = 1'b1; step(); underrun_clr = 1'b0;
        tswap = 1'b1; resolution = 6'd32;
        push_word(32'h12345678);
        tx_en = 1'b1;
        run(40, 1);
        tswap = 1'b0; resolution = 6'd16;
        for (int i = 0; i < 80; i++) begin
            clk_en = 1'b1;
            underrun_clr = ($urandom_range(0, 5) == 0) || (i % 17 == 16);
            step();
        end
        underrun_clr = 1'b0;
        tx_en = 1'b0;
        step();

        // Out-of-range resolution, then a change mid-slot.
        push_word(32'h00ABCDEF);
        push_word(32'h00FEDCBA);
        resolution = 6'd40;
        tx_en = 1'b1;
        run(8, 1);
        resolution = 6'd24;
        run(50, 1);
        tx_en = 1'b0;
        step();

        // Reset and enable drop mid-slot, each followed by a restart.
        for (int i = 0; i < 4; i++) push_word($urandom());
        tx_en = 1'b1;
        run(10, 1);
        rst = 1'b1; step(); rst = 1'b0;
        push_word(32'h0000F00F);
        run(10, 1);
        tx_en = 1'b0; step(); tx_en = 1'b1;
        run(20, 1);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            rst          = ($urandom_range(0, 299) == 0);
            tx_en        = ($urandom_range(0, 39) != 0);
            clk_en       = ($urandom_range(0, 1) == 0);
            resolution   = ($urandom_range(0, 1) == 0) ? 6'(16 + $urandom_range(0, 16))
                                                       : 6'($urandom_range(0, 63));
            tswap        = ($urandom_range(0, 1) == 0);
            wr_en        = ($urandom_range(0, 9) < 3);
            wr_data      = $urandom();
            underrun_clr = ($urandom_range(0, 9) == 0);
            step();
        end
        rst = 1'b0; tx_en = 1'b0; clk_en = 1'b0; wr_en = 1'b0; underrun_clr = 1'b0;
        step();

        repeat (2) @(posedge clk);
        #2;
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL exp_queue_drain got %0d pending required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
